// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and the fetch-queue entry type.
package riscv_pkg;
  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request accept, filled at
// response time and read from the head; flush empties it in one cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int FQ_DEPTH = 4,
  localparam int PW = $clog2(FQ_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            pop,
  output logic            head_valid,
  output fq_entry_t       head,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   unfilled
);
  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0] count_q, filled_q;
  fq_entry_t     mem [FQ_DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      filled_q  <= '0;
    end else begin
      if (alloc) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill)  fill_ptr  <= fill_ptr + PW'(1);
      if (pop)   rd_ptr    <= rd_ptr + PW'(1);
      count_q  <= count_q + CW'(alloc) - CW'(pop);
      filled_q <= filled_q + CW'(fill) - CW'(pop);
    end
  end

  // Entry storage carries no reset; validity lives entirely in the counters.
  always_ff @(posedge clk) begin
    if (alloc) mem[alloc_ptr].pc <= alloc_pc;
    if (fill)  mem[fill_ptr].instr <= fill_instr;
  end

  assign head_valid = (filled_q != '0);
  assign head       = mem[rd_ptr];
  assign count      = count_q;
  assign unfilled   = count_q - filled_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues imem requests, buffers
// in-order responses and presents InstrF/PCF/PCplus4F (or a NOP bubble) to ID.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCplus4F,
  output logic            ValidF
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt, count, unfilled;
  logic            head_valid, accept, rsp_taken, fill, pop;
  fq_entry_t       head;

  // Stale (dropped) responses still occupy a slot until they return.
  assign imem_req_valid = reset && !PCSrcE &&
                          (({1'b0, count} + {1'b0, drop_cnt}) < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_taken      = imem_rsp_valid && ((drop_cnt != '0) || (unfilled != '0));
  assign fill           = rsp_taken && (drop_cnt == '0) && !PCSrcE;
  assign pop            = head_valid && !StallF && !PCSrcE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (PCSrcE) begin
      fetch_pc <= PCTargetE;
      drop_cnt <= drop_cnt + unfilled - CW'(rsp_taken);
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_taken && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (PCSrcE),
    .alloc      (accept),
    .alloc_pc   (fetch_pc),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (count),
    .unfilled   (unfilled)
  );

  assign ValidF   = head_valid;
  assign InstrF   = head_valid ? head.instr : NOP_INSTR;
  assign PCF      = head_valid ? head.pc : '0;
  assign PCplus4F = PCF + PC_STEP;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with an in-order instruction memory
// model and a request/response-level reference model of the fetch stage.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset, StallF, PCSrcE, imem_req_ready, imem_rsp_valid;
  logic [31:0] PCTargetE, imem_rsp_data;
  logic        imem_req_valid, ValidF;
  logic [31:0] imem_req_addr, InstrF, PCF, PCplus4F;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrF(InstrF), .PCF(PCF),
    .PCplus4F(PCplus4F), .ValidF(ValidF)
  );

  typedef struct { logic [31:0] pc; bit live; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  req_t  outq[$];   // requests accepted, response not yet returned
  ent_t  rdyq[$];   // fetched instructions waiting for ID
  mreq_t mpipe[$];  // memory-side pending responses
  logic [31:0] m_pc;
  int cyc = 0, mem_lat = 1, tests = 0, fails = 0;
  bit jitter = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  function automatic logic exp_req_valid();
    return reset && !PCSrcE && ((outq.size() + rdyq.size()) < DEPTH);
  endfunction

  function automatic logic [129:0] exp_vec();
    logic v; logic [31:0] pi, pp;
    v = rdyq.size() > 0; pi = 32'h13; pp = 32'h0;
    if (v) begin pi = rdyq[0].instr; pp = rdyq[0].pc; end
    return {v, pi, pp, pp + 32'd4, exp_req_valid(), m_pc};
  endfunction

  function automatic logic [129:0] dut_vec();
    return {ValidF, InstrF, PCF, PCplus4F, imem_req_valid, imem_req_addr};
  endfunction

  task automatic begin_cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (reset && mpipe.size() > 0 && mpipe[0].due <= cyc &&
        (!jitter || $urandom_range(1, 0) == 1)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mpipe[0].addr);
    end
    @(negedge clk);
  endtask

  task automatic end_cycle();
    req_t r; ent_t e; mreq_t m; bit evalid, do_pop;
    if (!reset) begin
      outq.delete(); rdyq.delete(); mpipe.delete(); m_pc = RESET_PC;
    end else begin
      evalid = exp_req_valid();
      do_pop = rdyq.size() > 0 && !StallF;
      if (imem_rsp_valid) mpipe.delete(0);
      if (PCSrcE) begin
        if (imem_rsp_valid && outq.size() > 0) outq.delete(0);
        foreach (outq[i]) outq[i].live = 0;
        rdyq.delete();
        m_pc = PCTargetE;
      end else begin
        if (do_pop) rdyq.delete(0);
        if (imem_rsp_valid && outq.size() > 0) begin
          r = outq[0]; outq.delete(0);
          if (r.live) begin e.pc = r.pc; e.instr = imem_rsp_data; rdyq.push_back(e); end
        end
        if (evalid && imem_req_ready) begin
          r.pc = m_pc; r.live = 1; outq.push_back(r); m_pc = m_pc + 32'd4;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr; m.due = cyc + mem_lat; mpipe.push_back(m);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1;
    begin_cycle(); end_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_req_ready = 1'b1;
    begin_cycle(); end_cycle();
    begin_cycle();
    tests++;
    if ({ValidF, InstrF, PCF, PCplus4F, imem_req_valid} !== {1'b0, 32'h13, 32'h0, 32'h4, 1'b0}) begin
      fails++;
      $display("FAIL reset_values got V=%b I=%h PC=%h P4=%h RV=%b exp V=0 I=00000013 PC=0 P4=4 RV=0",
               ValidF, InstrF, PCF, PCplus4F, imem_req_valid);
    end
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
    end
    end_cycle();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ep;
    mem_lat = 1; jitter = 0;
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      if (k < 3) begin
        tests++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'(4 * k)}) begin
          fails++; $display("FAIL basic_req k=%0d got v=%b a=%h exp v=1 a=%h", k, imem_req_valid, imem_req_addr, 4 * k);
        end
      end
      tests++;
      if (ValidF !== (k >= 2)) begin
        fails++; $display("FAIL basic_validf k=%0d got=%b exp=%b", k, ValidF, k >= 2);
      end
      if (k >= 2) begin
        ep = 32'(4 * (k - 2));
        tests++;
        if ({PCF, PCplus4F, InstrF} !== {ep, ep + 32'd4, memfn(ep)}) begin
          fails++; $display("FAIL basic_stream k=%0d got pc=%h p4=%h i=%h exp pc=%h p4=%h i=%h",
                            k, PCF, PCplus4F, InstrF, ep, ep + 32'd4, memfn(ep));
        end
      end
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL basic_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      end_cycle();
    end
  endtask

  task automatic test_stall();
    bit found; logic [31:0] ep;
    apply_reset(); mem_lat = 1; jitter = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rdyq.size() > 0 && rdyq[0].pc == 32'h8) found = 1;
      else begin
        begin_cycle();
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++; $display("FAIL stall_pre got=%h exp=%h", dut_vec(), exp_vec());
        end
        end_cycle();
      end
    end
    if (!found) begin tests++; fails++; $display("FAIL stall_wait got=timeout exp=head pc 8"); end
    StallF = 1'b1;
    for (int s = 0; s < 3; s++) begin
      begin_cycle();
      tests++;
      if ({ValidF, InstrF, PCF, PCplus4F} !== {1'b1, 32'h0050_0093, 32'h8, 32'hC}) begin
        fails++; $display("FAIL stall_hold s=%0d got V=%b I=%h PC=%h P4=%h exp V=1 I=00500093 PC=8 P4=c",
                          s, ValidF, InstrF, PCF, PCplus4F);
      end
      if (s == 2) begin
        tests++;
        if ({imem_req_valid, dut.count} !== {1'b0, 3'd4}) begin
          fails++; $display("FAIL stall_full got rv=%b count=%0d exp rv=0 count=4", imem_req_valid, dut.count);
        end
      end
      end_cycle();
    end
    StallF = 1'b0; ep = 32'h8;
    for (int k = 0; k < 8; k++) begin
      begin_cycle();
      tests++;
      if ({ValidF, PCF, PCplus4F} !== {1'b1, ep, ep + 32'd4}) begin
        fails++; $display("FAIL stall_release k=%0d got V=%b PC=%h P4=%h exp V=1 PC=%h P4=%h",
                          k, ValidF, PCF, PCplus4F, ep, ep + 32'd4);
      end
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL stall_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
      ep = ep + 32'd4;
    end
  endtask

  // Redirect with outstanding requests; 'arrive' selects whether a response
  // lands in the redirect cycle itself (expected drop count 2 either way).
  task automatic test_redirect(input logic [31:0] tgt, input bit arrive);
    bit got_req, got_v;
    apply_reset(); mem_lat = 3; jitter = 0;
    StallF = arrive;
    for (int k = 0; k < (arrive ? 3 : 2); k++) begin
      begin_cycle();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL redir_pre got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
    PCSrcE = 1'b1; PCTargetE = tgt;
    begin_cycle();
    tests++;
    if ({imem_req_valid, imem_rsp_valid} !== {1'b0, arrive}) begin
      fails++; $display("FAIL redir_noreq got rv=%b rsp=%b exp rv=0 rsp=%b", imem_req_valid, imem_rsp_valid, arrive);
    end
    end_cycle();
    PCSrcE = 1'b0; StallF = 1'b0;
    tests++;
    if (dut.drop_cnt !== 3'd2) begin
      fails++; $display("FAIL redir_drop got=%0d exp=2", dut.drop_cnt);
    end
    got_req = 0; got_v = 0;
    for (int k = 0; k < 15 && !got_v; k++) begin
      begin_cycle();
      if (imem_req_valid && !got_req) begin
        got_req = 1; tests++;
        if (imem_req_addr !== tgt) begin
          fails++; $display("FAIL redir_addr got=%h exp=%h", imem_req_addr, tgt);
        end
      end
      if (ValidF) begin
        got_v = 1; tests++;
        if (PCF !== tgt) begin fails++; $display("FAIL redir_first_pc got=%h exp=%h", PCF, tgt); end
      end
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL redir_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
    if (!got_v) begin tests++; fails++; $display("FAIL redir_wait got=timeout exp=ValidF"); end
  endtask

  task automatic test_ready_low();
    apply_reset(); mem_lat = 1; jitter = 0;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      tests++;
      if ({imem_req_valid, imem_req_addr, ValidF, InstrF, PCF} !== {1'b1, RESET_PC, 1'b0, 32'h13, 32'h0}) begin
        fails++; $display("FAIL ready_low k=%0d got rv=%b a=%h V=%b I=%h PC=%h exp rv=1 a=%h V=0 I=13 PC=0",
                          k, imem_req_valid, imem_req_addr, ValidF, InstrF, PCF, RESET_PC);
      end
      end_cycle();
    end
    imem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      begin_cycle();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL ready_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] accs[$]; bit seen;
    mem_lat = 1; jitter = 0; StallF = 1'b0; imem_req_ready = 1'b1; seen = 0;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    begin_cycle(); end_cycle();
    PCSrcE = 1'b0;
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      if (imem_req_valid && imem_req_ready) accs.push_back(imem_req_addr);
      if (ValidF && PCF == 32'hFFFF_FFFC) begin
        seen = 1; tests++;
        if (PCplus4F !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got=%h exp=00000000", PCplus4F); end
      end
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL wrap_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
    tests++;
    if (accs.size() < 2 || !seen) begin
      fails++; $display("FAIL wrap_seen got accs=%0d seen=%b exp accs>=2 seen=1", accs.size(), seen);
    end else if ({accs[0], accs[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
      fails++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", accs[0], accs[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin mem_lat = $urandom_range(3, 1); jitter = $urandom_range(1, 0); end
      StallF = ($urandom_range(3, 0) == 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      PCSrcE = ($urandom_range(24, 0) == 0);
      t = $urandom; t[1:0] = 2'b00; PCTargetE = t;
      begin_cycle();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      end_cycle();
    end
    StallF = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1; jitter = 0;
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 20; k++) begin
      StallF = ($urandom_range(3, 0) == 0);
      begin_cycle();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL midreset_pre got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
    StallF = 1'b0; reset = 1'b0;
    begin_cycle(); end_cycle();
    reset = 1'b1;
    begin_cycle();
    tests++;
    if ({ValidF, InstrF, PCF, PCplus4F, imem_req_valid, imem_req_addr} !==
        {1'b0, 32'h13, 32'h0, 32'h4, 1'b1, RESET_PC}) begin
      fails++; $display("FAIL midreset_vals got V=%b I=%h PC=%h P4=%h rv=%b a=%h exp V=0 I=13 PC=0 P4=4 rv=1 a=%h",
                        ValidF, InstrF, PCF, PCplus4F, imem_req_valid, imem_req_addr, RESET_PC);
    end
    end_cycle();
    for (int k = 0; k < 10; k++) begin
      begin_cycle();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL midreset_post got=%h exp=%h", dut_vec(), exp_vec());
      end
      end_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    m_pc = RESET_PC; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect(32'h0000_0100, 1'b0);
    test_redirect(32'h0000_0200, 1'b1);
    test_ready_low();
    test_wrap();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline: the producer side of the IF→ID boundary. It owns the fetch PC, issues requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small fetch queue, and presents `InstrF`/`PCF`/`PCplus4F` to the decode-stage pipeline register. When no instruction is ready it presents a NOP bubble. It honours `StallF` from the hazard unit and branch/jump redirects from EX.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `FQ_DEPTH`, 4: fetch-queue entries, power of 2, at least 2.
- `clk` in 1: clock. One clock domain; reset is synchronous and active-low.
- `reset` in 1: synchronous, active-low reset.
- `StallF` in 1: hazard unit holds fetch; head entry is not consumed.
- `PCSrcE` in 1: redirect request from EX.
- `PCTargetE` in 32: redirect target.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: request address (the fetch PC).
- `imem_rsp_valid` in 1: response valid. Responses return in order, at least 1 cycle after accept, and have no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `InstrF` out 32: instruction to ID; NOP 32'h0000_0013 when not valid.
- `PCF` out 32: PC of `InstrF`; 0 when not valid.
- `PCplus4F` out 32: `PCF`+4 when valid; 4 when not valid.
- `ValidF` out 1: `InstrF` holds a real fetched instruction.

## Operation
- State:
  - `fetch_pc`.
  - Fetch queue: circular buffer of {pc, instr}, with alloc, fill and read pointers plus an entry count.
  - `drop_cnt`: responses still to be discarded.
- Request:
  - `imem_req_valid = reset_n && !PCSrcE && (count + drop_cnt < FQ_DEPTH)`. It is combinational and may drop without a handshake; memory acts only on valid&&ready.
  - `imem_req_addr = fetch_pc`.
  - On accept: allocate entry {pc = `fetch_pc`}, then `fetch_pc += 4` (wraps modulo 2^32).
- Response:
  - If `drop_cnt > 0`: decrement and discard the data.
  - Else: write instr at the fill pointer and advance the fill pointer.
  - A response with nothing outstanding is ignored.
- Output:
  - Head entry filled: drive head contents and `ValidF=1`.
  - Otherwise: drive the NOP bubble values.
  - Pop when head is filled and `!StallF`.
- Redirect (`PCSrcE=1`):
  - Next cycle `fetch_pc = PCTargetE`; all queue entries are discarded and the pointers reset.
  - `drop_cnt` = entries allocated but unfilled this cycle, minus 1 if a response arrives this cycle, plus the existing `drop_cnt`.
  - Redirect beats `StallF` and same-cycle pop; no request issues in the redirect cycle.
- Simultaneous accept, response and pop in one cycle: all three apply; count = count + accept − pop.
- `StallF` with head unfilled: outputs go from NOP to the instruction when the fill lands. ID's enable is low, so this is harmless.

## Timing
- Reset (`reset`=0 at a clock edge):
  - `fetch_pc=RESET_PC`, queue empty, `drop_cnt=0`.
  - Outputs: `ValidF=0`, `InstrF=0x00000013`, `PCF=0`, `PCplus4F=4`, `imem_req_valid=0`.
  - Reset mid-operation discards everything; later responses from before reset are not tracked, and memory must be reset together with this block.
- First request is valid in the first cycle after reset releases.
- Latency: accept at cycle t, earliest response at t+1 (written at the edge), `ValidF` at t+2. No response bypass.
- Throughput: 1 instruction/cycle requires `FQ_DEPTH` ≥ memory latency + 2. Default 4 covers 2-cycle memory.
- Full (count + drop_cnt = FQ_DEPTH): request withheld. Empty: bubble output.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN=32`.
  - `NOP_INSTR=32'h0000_0013`.
  - `PC_STEP=4`.
- One sub-module, `fetch_queue`: alloc/fill/read pointer buffer with count and a flush input.
- PC, `drop_cnt` and request logic stay in `if_fetch_unit`.

## Test plan
- Reset release, 1-cycle memory, `StallF`=0:
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - `ValidF` first rises 2 cycles after the first accept.
  - Then one instruction per cycle, with `PCplus4F=PCF+4`.
- `StallF`=1 for 3 cycles with the head holding 0x00500093 @PC 0x8:
  - Outputs stay constant.
  - Queue fills to 4 and `imem_req_valid` drops.
  - After release, PCs 0x8, 0xC, … follow without gaps.
- `PCSrcE`=1, `PCTargetE`=0x100 with 2 requests outstanding:
  - Next 2 responses are discarded.
  - Next request address is 0x100.
  - First valid output is PC 0x100; no stale PC appears.
- Redirect in the same cycle as a response and an accept-ready:
  - No request in that cycle.
  - `drop_cnt` is correct, e.g. 3 unfilled − 1 arriving = 2.
- `imem_req_ready`=0 for 5 cycles:
  - `imem_req_addr` holds the current PC.
  - Outputs show the NOP bubble (`InstrF`=0x13, `ValidF`=0).
- `fetch_pc`=0xFFFF_FFFC:
  - Next request address is 0x0000_0000.
  - `PCplus4F` for that entry = 0x0000_0000.
- `reset`=0 mid-stream:
  - Next cycle all outputs take their reset values.
  - Requests restart at `RESET_PC`.
